// File: rtl/cpu64_l2_arrays_pkg.sv
// Geometry constants, types and the byte-merge helper for the cpu64 L2 data/tag arrays.
// Latency: none (package only).
// Backpressure: none (package only).
package cpu64_l2_pkg;

  localparam int IDX_W  = 8;
  localparam int SETS   = 1 << IDX_W;
  localparam int WAYS   = 16;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WORDS  = 8;
  localparam int WORD_W = $clog2(WORDS);
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;
  localparam int TAG_W  = 50;

  typedef logic [TAG_W-1:0]  l2_tag_t;
  typedef logic [DATA_W-1:0] l2_word_t;
  typedef logic [BE_W-1:0]   l2_be_t;
  typedef logic [IDX_W-1:0]  l2_idx_t;
  typedef logic [WAY_W-1:0]  l2_way_t;
  typedef logic [WORD_W-1:0] l2_wsel_t;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic l2_word_t byte_merge(input l2_word_t old_w, input l2_word_t new_w,
                                          input l2_be_t be);
    l2_word_t res;
    res = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu64_l2_way_bank.sv
// One L2 way: SETS x WORDS data words with byte-merge write, plus one tag per set.
// Latency: combinational read; a write is visible right after the edge that performs it.
// Backpressure: none; one write per cycle, suppressed while rst_i is high.
// Optional CPU64_L2_ARRAYS_TAG_CLEAR_EN: tags become flops cleared to 0 on reset.
module cpu64_l2_way_bank
  import cpu64_l2_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  l2_idx_t  index_i,
  input  l2_wsel_t word_sel_i,
  input  logic     we_i,
  input  l2_be_t   be_i,
  input  l2_tag_t  tag_in_i,
  input  l2_word_t wdata_i,
  output l2_word_t rdata_o,
  output l2_tag_t  tag_o
);

  l2_word_t data_mem [SETS][WORDS];

  logic     tag_wr_d;
  logic     data_wr_d;
  l2_word_t wr_word_d;

  // Decode the write strobes and build the merged word from the current contents.
  always_comb begin
    tag_wr_d  = we_i & ~rst_i;
    data_wr_d = tag_wr_d & (|be_i);
    wr_word_d = byte_merge(data_mem[index_i][word_sel_i], wdata_i, be_i);
  end

  // Data storage is never reset; only the addressed word is rewritten.
  always_ff @(posedge clk_i) begin
    if (data_wr_d) data_mem[index_i][word_sel_i] <= wr_word_d;
  end

  assign rdata_o = data_mem[index_i][word_sel_i];

`ifdef CPU64_L2_ARRAYS_TAG_CLEAR_EN
  l2_tag_t tag_q [SETS];

  // Flop-based tags: reset clears every set, otherwise the addressed tag takes the new value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) tag_q[s] <= '0;
    end else if (tag_wr_d) begin
      tag_q[index_i] <= tag_in_i;
    end
  end

  assign tag_o = tag_q[index_i];
`else
  l2_tag_t tag_mem [SETS];

  // Uninitialised tag memory; reset only blocks the write.
  always_ff @(posedge clk_i) begin
    if (tag_wr_d) tag_mem[index_i] <= tag_in_i;
  end

  assign tag_o = tag_mem[index_i];
`endif

endmodule

// File: rtl/cpu64_l2_arrays.sv
// cpu64 L2 storage core: 16 way banks, flat all-way read buses and the way_sel read mux.
// Latency: combinational read of all ways; writes land on the rising clk_i edge.
// Backpressure: none; one write per cycle, writes ignored while rst_i is high.
// Optional CPU64_L2_ARRAYS_TAG_CLEAR_EN: tag array cleared to 0 by reset.
module cpu64_l2_arrays
  import cpu64_l2_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IDX_W-1:0]         index_i,
  input  logic [WORD_W-1:0]        word_sel_i,
  input  logic [WAY_W-1:0]         way_sel_i,
  input  logic                     write_en_i,
  input  logic [BE_W-1:0]          be_i,
  input  logic [TAG_W-1:0]         tag_in_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_selected_o,
  output logic [TAG_W-1:0]         tag_selected_o,
  output logic [WAYS*DATA_W-1:0]   rdata_way_flat_o,
  output logic [WAYS*TAG_W-1:0]    tag_way_flat_o
);

  l2_word_t way_rdata [WAYS];
  l2_tag_t  way_tag   [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_we;
    assign way_we = write_en_i & (way_sel_i == WAY_W'(w));

    cpu64_l2_way_bank u_bank (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .index_i    (index_i),
      .word_sel_i (word_sel_i),
      .we_i       (way_we),
      .be_i       (be_i),
      .tag_in_i   (tag_in_i),
      .wdata_i    (wdata_i),
      .rdata_o    (way_rdata[w]),
      .tag_o      (way_tag[w])
    );

    assign rdata_way_flat_o[w*DATA_W +: DATA_W] = way_rdata[w];
    assign tag_way_flat_o[w*TAG_W +: TAG_W]     = way_tag[w];
  end

  assign rdata_selected_o = way_rdata[way_sel_i];
  assign tag_selected_o   = way_tag[way_sel_i];

endmodule

// File: tb/tb_cpu64_l2_arrays.sv
// Self-checking bench for cpu64_l2_arrays: directed cases plus randomized writes/reads
// compared against an associative-array model of the cache contents.
module tb_cpu64_l2_arrays;
  import cpu64_l2_pkg::*;

`ifdef CPU64_L2_ARRAYS_TAG_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [IDX_W-1:0]       index_i;
  logic [WORD_W-1:0]      word_sel_i;
  logic [WAY_W-1:0]       way_sel_i;
  logic                   write_en_i;
  logic [BE_W-1:0]        be_i;
  logic [TAG_W-1:0]       tag_in_i;
  logic [DATA_W-1:0]      wdata_i;
  logic [DATA_W-1:0]      rdata_selected_o;
  logic [TAG_W-1:0]       tag_selected_o;
  logic [WAYS*DATA_W-1:0] rdata_way_flat_o;
  logic [WAYS*TAG_W-1:0]  tag_way_flat_o;

  always #5 clk_i = ~clk_i;

  cpu64_l2_arrays dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .index_i          (index_i),
    .word_sel_i       (word_sel_i),
    .way_sel_i        (way_sel_i),
    .write_en_i       (write_en_i),
    .be_i             (be_i),
    .tag_in_i         (tag_in_i),
    .wdata_i          (wdata_i),
    .rdata_selected_o (rdata_selected_o),
    .tag_selected_o   (tag_selected_o),
    .rdata_way_flat_o (rdata_way_flat_o),
    .tag_way_flat_o   (tag_way_flat_o)
  );

  // Reference model: only locations that have been written (or cleared) are known.
  logic [DATA_W-1:0] dm [int];
  logic [TAG_W-1:0]  tm [int];
  bit                tcleared = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [1023:0] obs, input logic [1023:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int dkey(input int i, input int w, input int wd);
    return i * 128 + w * 8 + wd;
  endfunction

  function automatic logic [DATA_W-1:0] exp_d(input int i, input int w, input int wd);
    if (dm.exists(dkey(i, w, wd))) return dm[dkey(i, w, wd)];
    return 'x;
  endfunction

  function automatic logic [TAG_W-1:0] exp_t(input int i, input int w);
    if (tm.exists(i * 16 + w)) return tm[i * 16 + w];
    if (tcleared) return '0;
    return 'x;
  endfunction

  // Compare every output against the model for the current read address.
  task automatic check_read(input string when);
    logic [DATA_W-1:0]      e;
    logic [TAG_W-1:0]       t;
    logic [WAYS*DATA_W-1:0] ed, md;
    logic [WAYS*TAG_W-1:0]  et, mt;
    e = exp_d(index_i, way_sel_i, word_sel_i);
    if (!$isunknown(e)) check({when, "_rd_sel"}, rdata_selected_o, e);
    t = exp_t(index_i, way_sel_i);
    if (!$isunknown(t)) check({when, "_tag_sel"}, tag_selected_o, t);
    ed = '0; md = '0; et = '0; mt = '0;
    for (int w = 0; w < WAYS; w++) begin
      e = exp_d(index_i, w, word_sel_i);
      if (!$isunknown(e)) begin ed[w*DATA_W +: DATA_W] = e; md[w*DATA_W +: DATA_W] = '1; end
      t = exp_t(index_i, w);
      if (!$isunknown(t)) begin et[w*TAG_W +: TAG_W] = t; mt[w*TAG_W +: TAG_W] = '1; end
    end
    if (md != '0) check({when, "_rd_flat"}, rdata_way_flat_o & md, ed);
    if (mt != '0) check({when, "_tag_flat"}, tag_way_flat_o & mt, et);
  endtask

  task automatic set_addr(input int i, input int wd, input int wy);
    index_i    = IDX_W'(i);
    word_sel_i = WORD_W'(wd);
    way_sel_i  = WAY_W'(wy);
  endtask

  // One write cycle: pre-write outputs checked, then the model applies the spec's rules.
  task automatic cyc_write(input logic rst, input int i, input int wd, input int wy,
                           input logic [BE_W-1:0] be, input logic [TAG_W-1:0] tg,
                           input logic [DATA_W-1:0] dat);
    logic [DATA_W-1:0] old;
    set_addr(i, wd, wy);
    rst_i = rst; write_en_i = 1'b1; be_i = be; tag_in_i = tg; wdata_i = dat;
    #1;
    check_read("pre");
    @(posedge clk_i);
    if (!rst) begin
      if (be != '0) begin
        old = exp_d(i, wy, wd);
        for (int b = 0; b < BE_W; b++) if (be[b]) old[8*b +: 8] = dat[8*b +: 8];
        dm[dkey(i, wy, wd)] = old;
      end
      tm[i * 16 + wy] = tg;
    end else if (CLR) begin
      tm.delete();
      tcleared = 1'b1;
    end
    #1;
    write_en_i = 1'b0; rst_i = 1'b0;
    #1;
    check_read("post");
  endtask

  task automatic reset_pulse();
    @(posedge clk_i); #1;
    rst_i = 1'b1; write_en_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    if (CLR) begin tm.delete(); tcleared = 1'b1; end
  endtask

  initial begin
    rst_i = 1'b1; write_en_i = 1'b0; be_i = '0; tag_in_i = '0; wdata_i = '0;
    set_addr(0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0;
    if (CLR) begin tcleared = 1'b1; #1; check("reset_tag_flat", tag_way_flat_o, '0); end

    // Neighbours of the target location, for isolation checks later.
    cyc_write(1'b0, 'h10, 2, 4, 8'hFF, 50'h0AAAA, 64'h4444444444444444);
    cyc_write(1'b0, 'h10, 3, 5, 8'hFF, 50'h0BBBB, 64'h3333333333333333);

    // Full write.
    cyc_write(1'b0, 'h10, 2, 5, 8'hFF, 50'h123456789ABC, 64'hDEADBEEFCAFEBABE);
    check("full_rd", rdata_selected_o, 64'hDEADBEEFCAFEBABE);
    check("full_tag", tag_selected_o, 50'h123456789ABC);
    check("full_flat5", rdata_way_flat_o[5*DATA_W +: DATA_W], 64'hDEADBEEFCAFEBABE);

    // Partial write of the low four bytes.
    cyc_write(1'b0, 'h10, 2, 5, 8'h0F, 50'h123456789ABC, 64'h0000000011111111);
    check("part_rd", rdata_selected_o, 64'hDEADBEEF11111111);
    check("part_tag", tag_selected_o, 50'h123456789ABC);

    // Isolation: neighbouring word and way untouched.
    set_addr('h10, 3, 5); #1;
    check("iso_word3", rdata_selected_o, 64'h3333333333333333);
    set_addr('h10, 2, 4); #1;
    check("iso_way4", rdata_selected_o, 64'h4444444444444444);
    check("iso_flat4", rdata_way_flat_o[4*DATA_W +: DATA_W], 64'h4444444444444444);

    // Write attempted under reset is dropped.
    cyc_write(1'b1, 'h10, 2, 5, 8'hFF, 50'h0BAD, 64'h1111111111111111);
    check("rst_block_rd", rdata_selected_o, 64'hDEADBEEF11111111);

    // be=0: data stays, tag updates.
    cyc_write(1'b0, 'h10, 2, 5, 8'h00, 50'h777, 64'hFFFFFFFFFFFFFFFF);
    check("be0_rd", rdata_selected_o, 64'hDEADBEEF11111111);
    check("be0_tag", tag_selected_o, 50'h777);

    // Index extremes.
    cyc_write(1'b0, 'hFF, 7, 15, 8'hFF, 50'h3FFFFFFFFFFFF, 64'hA5A5A5A5A5A5A5A5);
    cyc_write(1'b0, 'h00, 0, 0, 8'hFF, 50'h1, 64'h0123456789ABCDEF);

    // Randomized traffic over a few colliding sets.
    for (int n = 0; n < 400; n++) begin
      int i;
      logic [BE_W-1:0] be;
      case ($urandom_range(3))
        0: i = 'h00;
        1: i = 'h10;
        2: i = 'h11;
        default: i = 'hFF;
      endcase
      be = ($urandom_range(7) == 0) ? 8'h00 : BE_W'($urandom);
      if ($urandom_range(3) == 0) begin
        set_addr(i, $urandom_range(7), $urandom_range(15));
        #1;
        check_read("probe");
      end else begin
        cyc_write(($urandom_range(15) == 0), i, $urandom_range(7), $urandom_range(15),
                  be, {$urandom, $urandom}, {$urandom, $urandom});
      end
    end

`ifdef CPU64_L2_ARRAYS_TAG_CLEAR_EN
    reset_pulse();
    set_addr('h00, 0, 0); #1; check("clr_tag_00", tag_way_flat_o, '0);
    set_addr('h10, 0, 0); #1; check("clr_tag_10", tag_way_flat_o, '0);
    set_addr('hFF, 0, 0); #1; check("clr_tag_ff", tag_way_flat_o, '0);
`else
    reset_pulse();
    set_addr('h10, 2, 5); #1;
    check_read("after_rst");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu64_l2_arrays.md
Name: cpu64_l2_arrays

Overview:
- Storage core of the cpu64 L2 cache: a 16-way set-associative data array (8 x 64-bit words per line) plus a per-way tag array, 256 sets.
- Sits under the L2 controller, which owns hit/miss, LRU and coherence state. This block only stores, byte-merges and returns data/tags.
- Reads are combinational: all ways at once, for tag compare and victim inspection. The selected way is also muxed out.

Parameters:
- IDX_W, 8, set index width (SETS = 2**IDX_W = 256)
- WAYS, 16, associativity; way_sel width = $clog2(WAYS) = 4
- WORDS, 8, 64-bit words per line; word_sel width = $clog2(WORDS) = 3
- DATA_W, 64, word width; byte-enable width = DATA_W/8 = 8
- TAG_W, 50, tag width

Ports:
- clk_i  in  1  clock; all writes on rising edge
- rst_i  in  1  synchronous, active-high reset
- index_i  in  IDX_W  set index, shared by read and write
- word_sel_i  in  3  word within line, shared by read and write
- way_sel_i  in  4  way for write and for the *_selected_o mux
- write_en_i  in  1  write strobe
- be_i  in  8  byte enables; bit b covers wdata_i[8b+7:8b]
- tag_in_i  in  TAG_W  tag written with every write
- wdata_i  in  DATA_W  write data
- rdata_selected_o  out  DATA_W  data[index][way_sel][word_sel]
- tag_selected_o  out  TAG_W  tag[index][way_sel]
- rdata_way_flat_o  out  WAYS*DATA_W  slice [w*64 +: 64] = data[index][w][word_sel]
- tag_way_flat_o  out  WAYS*TAG_W  slice [w*50 +: 50] = tag[index][w]

Behaviour:
- Write occurs on the rising clk_i when write_en_i=1 and rst_i=0. It targets set index_i, way way_sel_i, word word_sel_i.
- For each b with be_i[b]=1, data byte b takes wdata_i byte b. Bytes with be_i[b]=0 keep their old value.
- be_i=0 with write_en_i=1: data is unchanged, but the tag is still written.
- Every write also sets tag[index_i][way_sel_i] = tag_in_i, regardless of be_i.
- No other way, word or set is touched by a write.
- Reads are asynchronous, a pure function of index_i, word_sel_i, way_sel_i and the current array contents.
- A write becomes visible on the outputs immediately after the clock edge that performs it. Zero-cycle read latency after the write edge.
- In the same cycle as a write, the outputs show pre-write contents. No write-through bypass.
- Reset: writes are suppressed while rst_i=1. Data array contents are not cleared. The tag array is not cleared unless the optional feature is enabled.
- No output has a reset value of its own; all outputs follow array contents.
- Unwritten locations read X in simulation. The controller must not rely on them.
- No handshake; one write per cycle maximum.
- Index wrap does not apply: every index_i value is a legal set.

Optional Feature:
- Macro CPU64_L2_ARRAYS_TAG_CLEAR_EN.
- Defined: the tag array is flop-based. On any clock edge with rst_i=1, all SETS*WAYS tags are cleared to 0, so tag outputs read 0 for every index after reset.
- Not defined: tags are uninitialised memory, same as the data array. Reset only blocks writes.

Decomposition:
- Package cpu64_l2_pkg holds the geometry constants (IDX_W, WAYS, WORDS, DATA_W, TAG_W, derived widths) and typedefs l2_tag_t, l2_word_t, l2_be_t.
- One natural sub-module, cpu64_l2_way_bank: one way's data+tag storage with byte-merge write. It is instantiated WAYS times, and the top level builds the flat buses and the way_sel mux.

Test Plan:
- Full write: index=0x10, word=2, way=5, be=0xFF, tag=0x123456789ABC, data=0xDEADBEEFCAFEBABE. Next cycle, same address, write_en=0 -> rdata_selected_o=0xDEADBEEFCAFEBABE, tag_selected_o=0x123456789ABC, rdata_way_flat_o[5*64 +: 64] matches.
- Partial write: same address, be=0x0F, data=0x0000000011111111 -> read 0xDEADBEEF11111111; tag unchanged at 0x123456789ABC.
- Isolation: write way 5 word 2, then read word 3 of way 5 and word 2 of way 4 -> both unchanged from their prior values. Flat slices for the other ways are unchanged.
- Reset blocking: rst_i=1 with write_en=1, data=0x1111111111111111 at index 0x10 way 5 word 2 -> contents still 0xDEADBEEF11111111 after reset deasserts.
- Same-cycle write: outputs show old data during the write cycle and new data the cycle after. be=0x00 leaves data intact but updates the tag.
- CPU64_L2_ARRAYS_TAG_CLEAR_EN defined: after a reset pulse, tag_way_flat_o = 0 for indices 0x00, 0x10 and 0xFF.
